// File: rtl/act_fun_batch_sequencer.sv
// Batch sequencer: streams a snapshot of NUM_INPUTS pre-activations through one shared
// fixed-latency activation engine and gathers the in-order results into an output vector.
module act_fun_batch_sequencer #(
  parameter int WIDTH      = 16,
  parameter int FRAC_BITS  = 13,
  parameter int NUM_INPUTS = 8,
  parameter int TIMEOUT    = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic [NUM_INPUTS*WIDTH-1:0] VALUES_IN,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        ERROR,
  output logic [NUM_INPUTS*WIDTH-1:0] VALUES_OUT,
  output logic [WIDTH-1:0]            ACT_VALUE_OUT,
  output logic                        ACT_VALID_OUT,
  input  logic [WIDTH-1:0]            ACT_VALUE_IN,
  input  logic                        ACT_VALID_IN
);

  localparam int RES_W = $clog2(NUM_INPUTS + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int VEC_W = NUM_INPUTS * WIDTH;

  localparam logic [RES_W-1:0] RES_ONE    = RES_W'(1);
  localparam logic [RES_W-1:0] RES_FULL   = RES_W'(NUM_INPUTS);
  localparam logic [RES_W-1:0] ISSUE_LAST = RES_W'(NUM_INPUTS - 1);
  localparam logic [TO_W-1:0]  TO_ONE     = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

  // Data is only routed, never interpreted, so the binary point is free as long as it fits.
  if (NUM_INPUTS < 1 || TIMEOUT < 1 || FRAC_BITS < 0 || FRAC_BITS > WIDTH) begin : g_bad_params
    $error("act_fun_batch_sequencer: illegal parameterisation");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e             state_r, state_s;
  logic [RES_W-1:0]   issue_idx_r, issue_idx_s;
  logic [RES_W-1:0]   result_idx_r, result_idx_s, result_cnt_s;
  logic [TO_W-1:0]    idle_cnt_r, idle_cnt_s, idle_inc_s;
  logic [VEC_W-1:0]   snapshot_r, snapshot_s;
  logic [VEC_W-1:0]   values_out_r, values_out_s;
  logic               error_r, error_s;
  logic               capture_window_s, accept_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               act_valid_r, act_valid_s;
  logic [WIDTH-1:0]   act_value_r, act_value_s;

  // Decide whether this cycle's engine result lands in a free slot.
  always_comb begin
    capture_window_s = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
    accept_s         = ACT_VALID_IN && capture_window_s && (result_idx_r < RES_FULL);
    if (accept_s) begin
      result_cnt_s = result_idx_r + RES_ONE;
    end else begin
      result_cnt_s = result_idx_r;
    end
    idle_inc_s = idle_cnt_r + TO_ONE;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_s      = state_r;
    issue_idx_s  = issue_idx_r;
    result_idx_s = result_cnt_s;
    idle_cnt_s   = idle_cnt_r;
    snapshot_s   = snapshot_r;
    values_out_s = values_out_r;
    error_s      = error_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_s      = ST_ISSUE;
          snapshot_s   = VALUES_IN;
          values_out_s = {VEC_W{1'b0}};
          error_s      = 1'b0;
          issue_idx_s  = {RES_W{1'b0}};
          result_idx_s = {RES_W{1'b0}};
          idle_cnt_s   = {TO_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_idx_r == ISSUE_LAST) begin
          // A zero-latency engine can finish while the last element is still going out.
          if (result_cnt_s == RES_FULL) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DRAIN;
          end
        end else begin
          issue_idx_s = issue_idx_r + RES_ONE;
        end
      end
      ST_DRAIN: begin
        if (result_cnt_s == RES_FULL) begin
          state_s = ST_DONE;
        end else if (accept_s) begin
          idle_cnt_s = {TO_W{1'b0}};
        end else begin
          idle_cnt_s = idle_inc_s;
          // The hand-over cycle into DONE is itself the last waited cycle.
          if (idle_inc_s >= TO_LAST) begin
            error_s = 1'b1;
            state_s = ST_DONE;
          end else begin
            state_s = ST_DRAIN;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    for (int i = 0; i < NUM_INPUTS; i++) begin
      values_out_s[i*WIDTH +: WIDTH] = (accept_s && (result_idx_r == RES_W'(i))) ?
                                       ACT_VALUE_IN : values_out_s[i*WIDTH +: WIDTH];
    end
    // Results with nowhere to go are dropped but flagged.
    error_s = error_s | (ACT_VALID_IN & ~accept_s);
  end

  // Output next values, derived from the state being entered so the flops line up with it.
  always_comb begin
    busy_s      = (state_s == ST_ISSUE) || (state_s == ST_DRAIN);
    done_s      = (state_s == ST_DONE);
    act_valid_s = (state_s == ST_ISSUE);
    act_value_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      act_value_s = (act_valid_s && (issue_idx_s == RES_W'(i))) ?
                    snapshot_s[i*WIDTH +: WIDTH] : act_value_s;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      issue_idx_r  <= {RES_W{1'b0}};
      result_idx_r <= {RES_W{1'b0}};
      idle_cnt_r   <= {TO_W{1'b0}};
      snapshot_r   <= {VEC_W{1'b0}};
      values_out_r <= {VEC_W{1'b0}};
      error_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      act_valid_r  <= 1'b0;
      act_value_r  <= {WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      issue_idx_r  <= issue_idx_s;
      result_idx_r <= result_idx_s;
      idle_cnt_r   <= idle_cnt_s;
      snapshot_r   <= snapshot_s;
      values_out_r <= values_out_s;
      error_r      <= error_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      act_valid_r  <= act_valid_s;
      act_value_r  <= act_value_s;
    end
  end

  assign BUSY          = busy_r;
  assign DONE          = done_r;
  assign ERROR         = error_r;
  assign VALUES_OUT    = values_out_r;
  assign ACT_VALUE_OUT = act_value_r;
  assign ACT_VALID_OUT = act_valid_r;

endmodule

// File: tb/tb_act_fun_batch_sequencer.sv
// Self-checking bench for act_fun_batch_sequencer: a queue-based engine model (x+1 after a
// programmable delay) plus a per-batch timing/data model derived from the sequencing rules.
module tb_act_fun_batch_sequencer;
  localparam int W  = 16;
  localparam int NI = 8;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [NI*W-1:0] values_in = '0;
  logic            busy, done, error;
  logic [NI*W-1:0] values_out;
  logic [W-1:0]    act_value_out;
  logic            act_valid_out;
  logic [W-1:0]    act_value_in = '0;
  logic            act_valid_in = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // engine model controls (written by tests) and state (written by the engine)
  int eng_lat = 4, eng_max = NI, eng_base = 0;
  bit eng_extra = 1'b0;
  int eng_issued = 0;
  int inj_seq = 0, inj_done = 0;
  typedef struct { int due; logic [W-1:0] val; } ent_t;
  ent_t eq[$];

  act_fun_batch_sequencer #(.WIDTH(W), .FRAC_BITS(13), .NUM_INPUTS(NI), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst), .START(start), .VALUES_IN(values_in),
    .BUSY(busy), .DONE(done), .ERROR(error), .VALUES_OUT(values_out),
    .ACT_VALUE_OUT(act_value_out), .ACT_VALID_OUT(act_valid_out),
    .ACT_VALUE_IN(act_value_in), .ACT_VALID_IN(act_valid_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: every issued x comes back as x+1, eng_lat cycles later.
  always @(negedge clk) begin : engine
    int n;
    act_valid_in = 1'b0;
    act_value_in = '0;
    if (eq.size() > 0 && eq[0].due == cyc) begin
      act_valid_in = 1'b1;
      act_value_in = eq[0].val;
      void'(eq.pop_front());
    end else if (inj_seq != inj_done) begin
      act_valid_in = 1'b1;
      act_value_in = 16'h1234;
      inj_done = inj_done + 1;
    end
    if (act_valid_out === 1'b1) begin
      eng_issued = eng_issued + 1;
      n = eng_issued - eng_base;
      if (n <= eng_max) eq.push_back('{due: cyc + eng_lat, val: act_value_out + 16'd1});
      if (eng_extra && n == NI) eq.push_back('{due: cyc + eng_lat + 1, val: 16'hBEEF});
    end
  end

  function automatic logic [NI*W-1:0] rand_vec();
    logic [NI*W-1:0] v;
    for (int i = 0; i < NI; i++) v[i*W +: W] = 16'($urandom);
    return v;
  endfunction

  // One batch: lat = engine delay, nres = results the engine returns, extra = one surplus
  // result after the last, ns1/ns2 = cycles carrying a START that must be ignored (0 = none).
  task automatic run_batch(input logic [NI*W-1:0] vals, input int lat, input int nres,
                           input bit extra, input int ns1, input int ns2, input string tag);
    int last, done_c;
    logic [NI*W-1:0] exp_vec;
    logic [W-1:0] exp_val;
    bit exp_err, exp_av;
    eng_lat = lat; eng_max = nres; eng_extra = extra; eng_base = eng_issued;
    last = (nres > 0) ? nres + lat : 0;
    if (nres == NI) done_c = NI + lat + 1;
    else done_c = ((last > NI) ? last : NI) + TO;
    for (int i = 0; i < NI; i++) exp_vec[i*W +: W] = (i < nres) ? vals[i*W +: W] + 16'd1 : 16'd0;
    exp_err = (nres < NI);
    @(posedge clk); #1;
    values_in = vals; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; values_in = rand_vec();
    for (int k = 1; k <= done_c + 1; k++) begin
      @(negedge clk);
      exp_av = (k <= NI);
      exp_val = exp_av ? vals[(k-1)*W +: W] : 16'd0;
      checks++;
      if (act_valid_out !== exp_av) begin
        failures++;
        $display("FAIL %s act_valid cyc %0d: got %b want %b", tag, k, act_valid_out, exp_av);
      end
      checks++;
      if (act_value_out !== exp_val) begin
        failures++;
        $display("FAIL %s act_value cyc %0d: got %h want %h", tag, k, act_value_out, exp_val);
      end
      checks++;
      if (busy !== (k < done_c)) begin
        failures++;
        $display("FAIL %s busy cyc %0d: got %b want %b", tag, k, busy, (k < done_c));
      end
      checks++;
      if (done !== (k == done_c)) begin
        failures++;
        $display("FAIL %s done cyc %0d: got %b want %b", tag, k, done, (k == done_c));
      end
      if (k == 1) begin
        checks++;
        if (error !== 1'b0) begin
          failures++;
          $display("FAIL %s error_cleared: got %b want 0", tag, error);
        end
      end
      if (k >= done_c) begin
        checks++;
        if (values_out !== exp_vec) begin
          failures++;
          $display("FAIL %s values_out cyc %0d: got %h want %h", tag, k, values_out, exp_vec);
        end
        checks++;
        if (error !== ((k == done_c) ? exp_err : (exp_err | extra))) begin
          failures++;
          $display("FAIL %s error cyc %0d: got %b want %b", tag, k, error,
                   ((k == done_c) ? exp_err : (exp_err | extra)));
        end
      end
      start = (k == ns1 || k == ns2) && (k <= done_c);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, error, act_valid_out} !== 4'b0000) begin
      failures++;
      $display("FAIL reset flags: got %b want 0000", {busy, done, error, act_valid_out});
    end
    checks++;
    if (act_value_out !== 16'd0) begin
      failures++;
      $display("FAIL reset act_value: got %h want 0", act_value_out);
    end
    checks++;
    if (values_out !== '0) begin
      failures++;
      $display("FAIL reset values_out: got %h want 0", values_out);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_nominal();
    logic [NI*W-1:0] v, want;
    v    = {16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, 16'h1000, 16'hE000, 16'h2000, 16'h0000};
    want = {16'h0000, 16'h0002, 16'h8001, 16'h8000, 16'h1001, 16'hE001, 16'h2001, 16'h0001};
    run_batch(v, 4, NI, 1'b0, 3, 13, "nominal");
    checks++;
    if (values_out !== want) begin
      failures++;
      $display("FAIL nominal_literal: got %h want %h", values_out, want);
    end
  endtask

  task automatic test_spurious();
    logic [NI*W-1:0] prev;
    @(posedge clk); #1;
    prev = values_out;
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL spurious_pre error: got %b want 0", error);
    end
    inj_seq = inj_seq + 1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL spurious error: got %b want 1", error);
    end
    checks++;
    if (values_out !== prev) begin
      failures++;
      $display("FAIL spurious values_out: got %h want %h", values_out, prev);
    end
  endtask

  task automatic test_reset_mid();
    eng_lat = 4; eng_max = NI; eng_extra = 1'b0; eng_base = eng_issued;
    @(posedge clk); #1;
    values_in = rand_vec(); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, act_valid_out, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid flags: got %b want 000", {busy, act_valid_out, done});
    end
    checks++;
    if (values_out !== '0) begin
      failures++;
      $display("FAIL reset_mid values_out: got %h want 0", values_out);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid late_result error: got %b want 1", error);
    end
    checks++;
    if ({busy, values_out} !== '0) begin
      failures++;
      $display("FAIL reset_mid idle: got busy %b values %h want 0", busy, values_out);
    end
    run_batch(rand_vec(), 4, NI, 1'b0, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    int lat, nres, ns;
    bit extra;
    for (int b = 0; b < 6; b++) begin
      lat   = $urandom_range(1, 6);
      nres  = ($urandom_range(0, 1) == 1) ? NI : $urandom_range(0, NI - 1);
      extra = (nres == NI) ? 1'($urandom_range(0, 1)) : 1'b0;
      ns    = $urandom_range(1, NI + lat + 1);
      run_batch(rand_vec(), lat, nres, extra, ns, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_spurious();
    run_batch(rand_vec(), 4, 5, 1'b0, 10, 0, "timeout");
    run_batch(rand_vec(), 3, NI, 1'b0, 0, 0, "after_timeout");
    run_batch(rand_vec(), 4, NI, 1'b1, 0, 0, "extra_result");
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
